// File: rtl/systolic_array_load_sequencer.sv
// systolic_array_load_sequencer
//   Sequences one tile load at a time into a systolic array: an optional
//   weight phase (N rows, gated on the array being drained) followed by an
//   input/partial phase (N rows, gated on the array input FIFO having room).
//   Rows are pulled from an upstream buffer with a valid/ready handshake and
//   replayed one cycle later on the array's registered load strobes.
//
//   Optional build macro: SA_LOAD_SEQ_STALL_CNT_EN
//     Adds stall_drain_cnt / stall_space_cnt, saturating counts of the cycles
//     spent waiting for drained / fifo_has_space.
module systolic_array_load_sequencer #(
    parameter int N   = 4,
    parameter int DW  = 16,
    parameter int GAP = 1
) (
    input  logic                 clk,
    input  logic                 RST,
    // command side
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_weights,
    // upstream row buffer
    input  logic                 row_valid,
    output logic                 row_ready,
    input  logic [N*DW-1:0]      row_data,
    input  logic [N*DW-1:0]      row_partial,
    // array status
    input  logic                 drained,
    input  logic                 fifo_has_space,
    // array memory-side load interface
    output logic                 weight_en,
    output logic                 input_en,
    output logic                 partial_en,
    output logic [$clog2(N)-1:0] row_in_en,
    output logic [$clog2(N)-1:0] row_ps_en,
    output logic [N*DW-1:0]      array_in,
    output logic [N*DW-1:0]      array_in_partials,
    // status
    output logic                 busy,
`ifdef SA_LOAD_SEQ_STALL_CNT_EN
    output logic [31:0]          stall_drain_cnt,
    output logic [31:0]          stall_space_cnt,
`endif
    output logic                 done
);

    localparam int             CW       = $clog2(N);
    localparam logic [CW-1:0]  LAST_ROW = CW'(N - 1);
    localparam logic [3:0]     GAP_V    = 4'(GAP);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_DRAIN = 3'd1;
    localparam logic [2:0] S_WAIT_SPACE = 3'd2;
    localparam logic [2:0] S_LOAD_W     = 3'd3;
    localparam logic [2:0] S_LOAD_IP    = 3'd4;
    localparam logic [2:0] S_FINISH     = 3'd5;

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_gap;
    logic            w_row_ready;
    logic            w_row_hs;
    logic            w_last_row;

    logic            r_weight_en;
    logic            r_input_en;
    logic            r_partial_en;
    logic [CW-1:0]   r_row_in_en;
    logic [CW-1:0]   r_row_ps_en;
    logic [N*DW-1:0] r_array_in;
    logic [N*DW-1:0] r_array_in_partials;
    logic            r_done;

    // Row acceptance: weights stream every cycle, inputs wait out the gap.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned, which would infer a latch.
        w_row_ready = 1'b0;
        case (r_state)
            S_LOAD_W:  w_row_ready = 1'b1;
            S_LOAD_IP: w_row_ready = (r_gap == 4'd0);
            default:   w_row_ready = 1'b0;
        endcase
    end

    assign w_row_hs   = row_valid & w_row_ready;
    assign w_last_row = (r_cnt == LAST_ROW);

    // Next-state selection for the load sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt = cmd_weights ? S_WAIT_DRAIN : S_WAIT_SPACE;
                end
            end
            S_WAIT_DRAIN: begin
                if (drained) begin
                    w_state_nxt = S_LOAD_W;
                end
            end
            S_WAIT_SPACE: begin
                if (fifo_has_space) begin
                    w_state_nxt = S_LOAD_IP;
                end
            end
            S_LOAD_W: begin
                // the array is known drained here, so no FIFO space check
                if (w_row_hs && w_last_row) begin
                    w_state_nxt = S_LOAD_IP;
                end
            end
            S_LOAD_IP: begin
                if (w_row_hs && w_last_row) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                if (r_gap == 4'd0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        // NOTE: clocked state always uses non-blocking assignment so every
        // register samples pre-edge values regardless of block ordering.
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Row counter: advances per accepted row and wraps at N (not 2**CW).
    always_ff @(posedge clk) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (w_row_hs) begin
            r_cnt <= w_last_row ? '0 : r_cnt + CW'(1);
        end
    end

    // Gap counter: reloaded by each input row, then drains one per cycle.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_gap <= 4'd0;
        end else if (w_row_hs && (r_state == S_LOAD_IP)) begin
            r_gap <= GAP_V;
        end else if (r_gap != 4'd0) begin
            r_gap <= r_gap - 4'd1;
        end
    end

    // Registered load strobes, indices and data; all zero when idle.
    always_ff @(posedge clk) begin
        // NOTE: the data buses are reset too, since they must read zero in
        // every cycle without a strobe, including the one after reset.
        if (RST) begin
            r_weight_en         <= 1'b0;
            r_input_en          <= 1'b0;
            r_partial_en        <= 1'b0;
            r_row_in_en         <= '0;
            r_row_ps_en         <= '0;
            r_array_in          <= '0;
            r_array_in_partials <= '0;
            r_done              <= 1'b0;
        end else begin
            r_weight_en         <= 1'b0;
            r_input_en          <= 1'b0;
            r_partial_en        <= 1'b0;
            r_row_in_en         <= '0;
            r_row_ps_en         <= '0;
            r_array_in          <= '0;
            r_array_in_partials <= '0;
            r_done              <= (r_state == S_FINISH) && (r_gap == 4'd0);
            if (w_row_hs) begin
                if (r_state == S_LOAD_W) begin
                    r_weight_en <= 1'b1;
                    r_row_in_en <= r_cnt;
                    r_array_in  <= row_data;
                end else begin
                    r_input_en          <= 1'b1;
                    r_partial_en        <= 1'b1;
                    r_row_in_en         <= r_cnt;
                    r_row_ps_en         <= r_cnt;
                    r_array_in          <= row_data;
                    r_array_in_partials <= row_partial;
                end
            end
        end
    end

`ifdef SA_LOAD_SEQ_STALL_CNT_EN
    logic [31:0] r_stall_drain_cnt;
    logic [31:0] r_stall_space_cnt;

    // Saturating stall counters; only reset clears them, never a command.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_stall_drain_cnt <= '0;
            r_stall_space_cnt <= '0;
        end else begin
            if ((r_state == S_WAIT_DRAIN) && !drained && (r_stall_drain_cnt != '1)) begin
                r_stall_drain_cnt <= r_stall_drain_cnt + 32'd1;
            end
            if ((r_state == S_WAIT_SPACE) && !fifo_has_space && (r_stall_space_cnt != '1)) begin
                r_stall_space_cnt <= r_stall_space_cnt + 32'd1;
            end
        end
    end

    assign stall_drain_cnt = r_stall_drain_cnt;
    assign stall_space_cnt = r_stall_space_cnt;
`endif

    assign cmd_ready         = (r_state == S_IDLE);
    assign busy              = (r_state != S_IDLE);
    assign row_ready         = w_row_ready;
    assign weight_en         = r_weight_en;
    assign input_en          = r_input_en;
    assign partial_en        = r_partial_en;
    assign row_in_en         = r_row_in_en;
    assign row_ps_en         = r_row_ps_en;
    assign array_in          = r_array_in;
    assign array_in_partials = r_array_in_partials;
    assign done              = r_done;

endmodule
